multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 95 +++++++++
 tb/tb_multicycle_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32 control FSM; optional memory timeout under MULTICYCLE_CTRL_TIMEOUT_EN
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_load,
  output logic        imm_latch,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t st, nxt;
  logic [6:0] op;
  logic legal, is_f, is_d, is_e, is_m, is_w, waiting, tmo, unused_bits;
  assign op = instr[6:0];
  assign state = st;
  assign legal = op inside {7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111, 7'd115};
  // state qualifiers are gated by rst_n so every strobe is low while reset is held
  assign is_f = rst_n && st == FETCH;
  assign is_d = rst_n && st == DECODE;
  assign is_e = rst_n && st == EXEC;
  assign is_m = rst_n && st == MEM;
  assign is_w = rst_n && st == WB;
  // combinational strobe decode from state, opcode and handshake inputs
  always_comb begin
    mem_req      = is_f | is_m;
    mem_we       = is_m && op == 7'd35;
    mem_is_fetch = is_f;
    ir_load      = is_f && mem_ready;
    imm_latch    = is_d;
    alu_src_b    = is_e && op inside {7'd3, 7'd19, 7'd23, 7'd35, 7'd103};
    reg_we       = is_w && instr[11:7] != 5'd0;
    wb_sel       = !is_w ? 2'd0 : op == 7'd3 ? 2'd1 : (op == 7'd103 || op == 7'd111) ? 2'd2 : 2'd0;
    pc_load      = (is_e && op == 7'd99) | (is_m && op == 7'd35 && mem_ready) | is_w;
    pc_src       = (is_e && op == 7'd99 && branch_taken) ? 2'd1 :
                   (is_w && op == 7'd111) ? 2'd1 :
                   (is_w && op == 7'd103) ? 2'd2 : 2'd0;
    waiting      = mem_req && !mem_ready;
  end
  // next-state selection; unused encodings fall into HALT
  always_comb begin
    case (st)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = (op == 7'd115 || !legal) ? HALT : EXEC;
      EXEC:    nxt = (op == 7'd3 || op == 7'd35) ? MEM : op == 7'd99 ? FETCH : WB;
      MEM:     nxt = !mem_ready ? MEM : op == 7'd35 ? FETCH : WB;
      WB:      nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // state, sticky illegal flag and retire counter; every retiring path asserts pc_load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= FETCH;
      illegal <= 1'b0;
      retired <= 32'd0;
    end else begin
      st <= tmo ? HALT : nxt;
      if (is_d && !legal) illegal <= 1'b1;
      if (pc_load) retired <= retired + 32'd1;
    end
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES);
  logic [7:0] tcnt;
  assign tmo = waiting && (tcnt + 8'd1) == TMAX;
  assign unused_bits = ^instr[31:12];
  // wait-cycle counter clears on a completed access or any state change; expiry forces HALT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt    <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      tcnt <= (waiting && nxt == st && !tmo) ? tcnt + 8'd1 : 8'd0;
      if (tmo) bus_err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign bus_err = 1'b0;
  assign unused_bits = ^{instr[31:12], TIMEOUT_CYCLES, waiting};
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl with directed per-cycle expectations
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic [31:0] instr = 32'h0;
  logic mem_req, mem_we, mem_is_fetch, ir_load, imm_latch, alu_src_b, reg_we, pc_load, illegal, bus_err;
  logic [1:0] wb_sel, pc_src;
  logic [2:0] state;
  logic [31:0] retired;
  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_load(ir_load),
    .imm_latch(imm_latch), .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_load(pc_load), .pc_src(pc_src), .state(state), .illegal(illegal), .bus_err(bus_err),
    .retired(retired)
  );
  always #5 clk = ~clk;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;
  localparam logic [11:0] NONE = 12'h000, MREQ = 12'h800, MWE = 12'h400, FET = 12'h200, IRL = 12'h100,
                          IMM = 12'h080, ASB = 12'h040, RWE = 12'h020, WB2 = 12'h010, WB1 = 12'h008,
                          PCL = 12'h004, PS2 = 12'h002, PS1 = 12'h001;
  localparam logic [11:0] FDONE = MREQ | FET | IRL, FWAIT = MREQ | FET;
  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic [11:0] sb;
    logic        ill;
    logic        be;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  wire [11:0] sb_act = {mem_req, mem_we, mem_is_fetch, ir_load, imm_latch, alu_src_b, reg_we, wb_sel, pc_load, pc_src};
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({state, sb_act, illegal, bus_err, retired} !== {e.st, e.sb, e.ill, e.be, e.ret}) begin
        fails++;
        $display("FAIL %s: got state=%0d strobes=%03h illegal=%b bus_err=%b retired=%0d, want state=%0d strobes=%03h illegal=%b bus_err=%b retired=%0d",
                 e.nm, state, sb_act, illegal, bus_err, retired, e.st, e.sb, e.ill, e.be, e.ret);
      end
    end
  task automatic chk(input string nm, input logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s: state=%0d illegal=%b bus_err=%b retired=%0d mem_req=%b mem_we=%b",
               nm, state, illegal, bus_err, retired, mem_req, mem_we);
    end
  endtask
  task automatic step(input string nm, input logic r, input logic mr, input logic bt, input logic [2:0] st,
                      input logic [11:0] sb, input logic ill, input logic be, input logic [31:0] ret);
    exp_t e;
    rst_n = r;
    mem_ready = mr;
    branch_taken = bt;
    e.nm = nm; e.st = st; e.sb = sb; e.ill = ill; e.be = be; e.ret = ret;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    instr = 32'h00500093;
    step("reset_hold", 0, 1, 0, F, NONE, 0, 0, 0);
    chk("reset_state", state == F && illegal == 1'b0 && bus_err == 1'b0 && retired == 32'd0 &&
                       !mem_req && !mem_we && !pc_load && !reg_we);
    step("addi_fetch", 1, 1, 0, F, FDONE, 0, 0, 0);
    step("addi_dec", 1, 1, 0, D, IMM, 0, 0, 0);
    step("addi_exec", 1, 1, 0, E, ASB, 0, 0, 0);
    step("addi_wb", 1, 1, 0, W, RWE | PCL, 0, 0, 0);
    instr = 32'h00000063;
    step("beq1_fetch", 1, 1, 1, F, FDONE, 0, 0, 1);
    step("beq1_dec", 1, 1, 1, D, IMM, 0, 0, 1);
    step("beq1_exec", 1, 1, 1, E, PCL | PS1, 0, 0, 1);
    step("beq0_fetch", 1, 1, 0, F, FDONE, 0, 0, 2);
    step("beq0_dec", 1, 1, 0, D, IMM, 0, 0, 2);
    step("beq0_exec", 1, 1, 0, E, PCL, 0, 0, 2);
    instr = 32'h00112023;
    step("sw_fetch", 1, 1, 0, F, FDONE, 0, 0, 3);
    step("sw_dec", 1, 1, 0, D, IMM, 0, 0, 3);
    step("sw_exec", 1, 1, 0, E, ASB, 0, 0, 3);
    for (int i = 0; i < 3; i++) step("sw_mem_wait", 1, 0, 0, M, MREQ | MWE, 0, 0, 3);
    step("sw_mem_done", 1, 1, 0, M, MREQ | MWE | PCL, 0, 0, 3);
    instr = 32'h0000A083;
    step("lw_fetch", 1, 1, 0, F, FDONE, 0, 0, 4);
    step("lw_dec", 1, 1, 0, D, IMM, 0, 0, 4);
    step("lw_exec", 1, 1, 0, E, ASB, 0, 0, 4);
    step("lw_mem", 1, 1, 0, M, MREQ, 0, 0, 4);
    step("lw_wb", 1, 1, 0, W, RWE | WB1 | PCL, 0, 0, 4);
    instr = 32'h000080E7;
    step("jalr_fetch", 1, 1, 0, F, FDONE, 0, 0, 5);
    step("jalr_dec", 1, 1, 0, D, IMM, 0, 0, 5);
    step("jalr_exec", 1, 1, 0, E, ASB, 0, 0, 5);
    step("jalr_wb", 1, 1, 0, W, RWE | WB2 | PCL | PS2, 0, 0, 5);
    instr = 32'h0000006F;
    step("jal_fetch", 1, 1, 0, F, FDONE, 0, 0, 6);
    step("jal_dec", 1, 1, 0, D, IMM, 0, 0, 6);
    step("jal_exec", 1, 1, 0, E, NONE, 0, 0, 6);
    step("jal_wb_rd0", 1, 1, 0, W, WB2 | PCL | PS1, 0, 0, 6);
    instr = 32'h00112023;
    step("abort_fetch", 1, 1, 0, F, FDONE, 0, 0, 7);
    step("abort_dec", 1, 1, 0, D, IMM, 0, 0, 7);
    step("abort_exec", 1, 1, 0, E, ASB, 0, 0, 7);
    step("abort_mem", 1, 0, 0, M, MREQ | MWE, 0, 0, 7);
    step("abort_rst", 0, 1, 0, F, NONE, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("to_wait", 1, 0, 0, F, FWAIT, 0, 0, 0);
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    step("to_halt", 1, 0, 0, H, NONE, 0, 1, 0);
    chk("timeout_expired", state == H && bus_err == 1'b1);
    step("to_halt_hold", 1, 1, 0, H, NONE, 0, 1, 0);
`else
    for (int i = 0; i < 6; i++) step("to_stay", 1, 0, 0, F, FWAIT, 0, 0, 0);
    chk("no_timeout_wait", state == F && bus_err == 1'b0);
`endif
    instr = 32'h00000073;
    step("ecall_rst", 0, 0, 0, F, NONE, 0, 0, 0);
    step("ecall_fetch", 1, 1, 0, F, FDONE, 0, 0, 0);
    step("ecall_dec", 1, 1, 0, D, IMM, 0, 0, 0);
    step("ecall_halt", 1, 1, 0, H, NONE, 0, 0, 0);
    instr = 32'h0000007F;
    step("ill_rst", 0, 1, 0, F, NONE, 0, 0, 0);
    step("ill_fetch", 1, 1, 0, F, FDONE, 0, 0, 0);
    step("ill_dec", 1, 1, 0, D, IMM, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("ill_halt", 1, i[0], ~i[0], H, NONE, 1, 0, 0);
    step("ill_clear", 0, 1, 1, F, NONE, 0, 0, 0);
    step("post_rst_fetch", 1, 1, 0, F, FDONE, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
